// File: rtl/quant_serializer.sv
// Quantize one signed N-bit word (MSB-index window, truncate, saturate) and shift it out MSB-first.
// Latency: start accepted at edge 0, bits registered on edges 2..p+1, done with the last bit.
// Backpressure: none; start is ignored while busy, inputs are sampled only on the accepting edge.
//
// Ports: clk, rst (sync, active-high), start, din[N], msbidx[MSBW], prec[PRW] in;
//        dout, dout_valid, busy, done out (all registered).
// Optional build macro: QSER_RELU_EN fuses a ReLU into quantization (negative values become 0).
module quant_serializer #(
    parameter int N    = 32,
    parameter int QBW  = 8,
    parameter int MSBW = 5,
    parameter int PRW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    din,
    input  logic [MSBW-1:0] msbidx,
    input  logic [PRW-1:0]  prec,
    output logic            dout,
    output logic            dout_valid,
    output logic            busy,
    output logic            done
);

    // Wide enough to hold din shifted left by up to QBW-1 without losing bits.
    localparam int W = N + QBW;

    typedef enum logic [1:0] {S_IDLE, S_QUANT, S_SHIFT} state_t;

    state_t          state_q;
    logic [N-1:0]    din_q;
    logic [MSBW-1:0] msb_q;
    logic [PRW-1:0]  p_q;
    logic [PRW-1:0]  cnt_q;
    logic [QBW-1:0]  sr_q;
    logic [QBW-1:0]  sr_d;

    logic [MSBW-1:0] msb_in;
    logic [PRW-1:0]  p_in;

    // Input sanitising: msbidx beyond the word maps to the top bit, precision forced into 1..QBW.
    always_comb begin
        msb_in = msbidx;
        if (int'(msbidx) > N - 1) msb_in = MSBW'(N - 1);
        p_in = prec;
        if (prec == '0)                p_in = PRW'(1);
        else if (int'(prec) > QBW)     p_in = PRW'(QBW);
    end

    logic signed [W-1:0] ext;
    logic signed [W-1:0] v;
    logic signed [W-1:0] maxv;
    logic signed [W-1:0] minv;
    logic signed [W-1:0] one_w;
    logic [QBW-1:0]      q;
    int                  s;

    // Quantization of the latched word. s is the LSB position of the selected window;
    // a negative s means the window reaches below bit 0, so the word is scaled up instead.
    always_comb begin
        one_w = {{(W-1){1'b0}}, 1'b1};
        ext   = {{QBW{din_q[N-1]}}, din_q};
        s     = int'(msb_q) - int'(p_q) + 1;
        if (s >= 0) v = ext >>> s;
        else        v = ext <<< (-s);
        maxv = (one_w <<< (int'(p_q) - 1)) - one_w;
        minv = -maxv - one_w;
`ifdef QSER_RELU_EN
        if (v < 0) v = '0;
`endif
        if (v > maxv)      v = maxv;
        else if (v < minv) v = minv;
        q    = v[QBW-1:0];
        // Left-align the p-bit result so the serial bit is always the register MSB.
        sr_d = q << (QBW - int'(p_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            din_q      <= '0;
            msb_q      <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            sr_q       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= start;
                    if (start) begin
                        din_q   <= din;
                        msb_q   <= msb_in;
                        p_q     <= p_in;
                        state_q <= S_QUANT;
                    end
                end
                S_QUANT: begin
                    sr_q    <= sr_d;
                    cnt_q   <= '0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    dout       <= sr_q[QBW-1];
                    dout_valid <= 1'b1;
                    sr_q       <= {sr_q[QBW-2:0], 1'b0};
                    cnt_q      <= cnt_q + PRW'(1);
                    // busy stays high through the done cycle; it drops on the next IDLE edge.
                    if (cnt_q == p_q - PRW'(1)) begin
                        done    <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quant_serializer.sv
// Bench for quant_serializer: directed vectors with hand-derived bit patterns, randomized words
// checked against an arithmetic reference model, continuous-start throughput and mid-transfer reset.
module tb_quant_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] din;
    logic [4:0]  msbidx;
    logic [3:0]  prec;
    logic        dout, dout_valid, busy, done;

    int vec_cnt = 0;
    int err_cnt = 0;

    quant_serializer #(.N(32), .QBW(8), .MSBW(5), .PRW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .msbidx     (msbidx),
        .prec       (prec),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input logic [3:0] pr);
        if (pr == 0) return 1;
        if (pr > 8)  return 8;
        return int'(pr);
    endfunction

    // Reference: select window by MSB index, floor-divide or scale by a power of two, then saturate.
    function automatic longint qval(input logic [31:0] d, input int m, input int pe);
        longint v, mx;
        int sh;
        if (m > 31) m = 31;
        v  = longint'($signed(d));
        sh = m - pe + 1;
        if (sh >= 0) v = v >>> sh;
        else         v = v * (longint'(1) << (-sh));
        mx = (longint'(1) << (pe - 1)) - 1;
`ifdef QSER_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > mx)      v = mx;
        if (v < -mx - 1) v = -mx - 1;
        return v;
    endfunction

    // Called just after a negedge with the DUT idle; returns just after the negedge following edge p+2.
    task automatic run_word(input logic [31:0] d, input logic [4:0] m, input logic [3:0] pr,
                            input logic [7:0] exp_v, input int p);
        din = d; msbidx = m; prec = pr; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; din = $urandom; msbidx = 5'($urandom); prec = 4'($urandom);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_vld", 32'(dout_valid), 32'd0);
        @(negedge clk);
        chk("quant_vld", 32'(dout_valid), 32'd0);
        chk("quant_busy", 32'(busy), 32'd1);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            chk("bit_vld", 32'(dout_valid), 32'd1);
            chk("bit_val", 32'(dout), 32'(exp_v[p-1-i]));
            chk("bit_done", 32'(done), 32'(i == p - 1));
            chk("bit_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_vld", 32'(dout_valid), 32'd0);
        chk("end_done", 32'(done), 32'd0);
        chk("end_dout", 32'(dout), 32'd0);
    endtask

    logic [31:0] dh [0:17];

    initial begin
        logic [31:0] d;
        logic [4:0]  m;
        logic [3:0]  pr;
        longint      v;
        logic [7:0]  ev;
        int          ph, j;

        rst = 1'b1; start = 1'b0; din = '0; msbidx = '0; prec = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_vld", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-derived results.
        run_word(32'd100, 5'd7, 4'd8, 8'b01100100, 8);
        run_word(32'd1000, 5'd7, 4'd8, 8'b01111111, 8);
`ifdef QSER_RELU_EN
        run_word(-32'sd1000, 5'd7, 4'd8, 8'b00000000, 8);
        run_word(-32'sd5, 5'd2, 4'd4, 8'b00000000, 4);
        run_word(-32'sd1, 5'd0, 4'd0, 8'b00000000, 1);
`else
        run_word(-32'sd1000, 5'd7, 4'd8, 8'b10000000, 8);
        run_word(-32'sd5, 5'd2, 4'd4, 8'b00001000, 4);
        run_word(-32'sd1, 5'd0, 4'd0, 8'b00000001, 1);
`endif
        run_word(32'd3840, 5'd11, 4'd4, 8'b00000111, 4);
        run_word(32'd100, 5'd7, 4'd15, 8'b01100100, 8);

        // Randomized words against the reference model.
        for (int k = 0; k < 40; k++) begin
            d  = $urandom;
            d  = 32'($signed(d) >>> $urandom_range(0, 30));
            m  = 5'($urandom_range(0, 31));
            pr = 4'($urandom_range(0, 15));
            v  = qval(d, int'(m), eff_p(pr));
            ev = 8'(v);
            run_word(d, m, pr, ev, eff_p(pr));
        end

        // start held high: only words sampled at edges 0, 6, 12 are emitted (p=4).
        msbidx = 5'd9; prec = 4'd4; start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            din   = $urandom_range(0, 4095) - 2048;
            dh[c] = din;
            @(posedge clk); @(negedge clk);
            ph = c % 6;
            j  = c / 6;
            if (ph >= 2) begin
                v = qval(dh[j*6], 9, 4);
                chk("cont_vld", 32'(dout_valid), 32'd1);
                chk("cont_bit", 32'(dout), 32'((v >> (5 - ph)) & 1));
                chk("cont_done", 32'(done), 32'(ph == 5));
            end else begin
                chk("cont_gap_vld", 32'(dout_valid), 32'd0);
                chk("cont_gap_busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("cont_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of an 8-bit transfer aborts it.
        din = 32'd100; msbidx = 5'd7; prec = 4'd8; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 2) chk("pre_rst_vld", 32'(dout_valid), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_vld", 32'(dout_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_vld", 32'(dout_valid), 32'd0);
        end
        run_word(32'd1000, 5'd7, 4'd8, 8'b01111111, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/quant_serializer.md
Name: quant_serializer

Overview:
- Sits directly downstream of the max-pooling stage in the MVU output path.
- Takes one N-bit signed pooled/accumulated word and quantizes it to a runtime-selected precision: bit-window selection by MSB index, truncation, then saturation.
- Shifts the quantized result out MSB-first as a bit-serial stream for write-back into bit-transposed MVU memory.
- Start/busy/done handshake; one word in flight at a time.

Parameters:
- N, 32, input word width (signed).
- QBW, 8, maximum output precision in bits.
- MSBW, 5, width of msbidx; must satisfy 2^MSBW >= N.
- PRW, 4, width of prec; must satisfy 2^PRW > QBW.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to quantize din; sampled only in IDLE.
- din  in  N  signed input word (maxpool output).
- msbidx  in  MSBW  bit index of din mapped to output MSB.
- prec  in  PRW  output precision in bits, 1..QBW.
- dout  out  1  serial output bit.
- dout_valid  out  1  dout carries a valid bit this cycle.
- busy  out  1  high from the accepting edge until the done cycle, inclusive.
- done  out  1  one-cycle pulse coincident with the last output bit.

Behaviour:
- Reset: synchronous, active-high. Forces state IDLE; dout=0, dout_valid=0, busy=0, done=0; clears the latched word and bit counter. Reset mid-operation aborts with no further output bits.
- States:
  - IDLE: start=1 latches din, msbidx and prec (p; prec=0 → 1, prec>QBW → QBW). Goes to QUANT; busy=1 from the next cycle.
  - QUANT: one cycle.
    - s = msbidx - p + 1, signed.
    - s >= 0: v = din >>> s (arithmetic shift, truncation toward -inf).
    - s < 0: v = din << (-s), computed in N+QBW bits, no overflow loss.
    - Clamp v to [-2^(p-1), 2^(p-1)-1]; load the low p bits into the shift register.
    - Goes to SHIFT.
  - SHIFT: p cycles.
    - Each cycle: dout = current MSB, dout_valid=1, shift left, counter++.
    - On the p-th bit: done=1 for that cycle, go to IDLE.
- Timing:
  - Start accepted at edge 0 → first valid bit registered at edge 2, last bit at edge p+1.
  - busy falls at edge p+2; the next start is accepted at edge p+2 at the earliest. Throughput is one word per p+2 cycles.
- start while busy: ignored, no queuing. Inputs are not re-sampled mid-operation.
- Outside SHIFT: dout=0, dout_valid=0.
- msbidx >= N: treated as N-1.

Optional Feature:
- QSER_RELU_EN
  - Defined: in QUANT, negative v is forced to 0 before the clamp (ReLU fused into quantization); saturation range becomes [0, 2^(p-1)-1].
  - Undefined: full signed saturation as above; no ReLU logic is synthesized.

Test Plan:
- din=100, msbidx=7, prec=8, start pulse → bits 0,1,1,0,0,1,0,0 on edges 2..9; done on edge 9; busy low at edge 10.
- din=1000, msbidx=7, prec=8 → saturates to 127: 0,1,1,1,1,1,1,1. din=-1000 → -128: 1,0,0,0,0,0,0,0.
- din=3840, msbidx=11, prec=4 → shift 8 gives 15, saturates to 7: 0,1,1,1. din=-5, msbidx=2, prec=4 → left shift 1 gives -10, saturates to -8: 1,0,0,0.
- start held high continuously with changing din → only words sampled at edges 0, p+2, 2(p+2) are emitted; no bit is lost or duplicated.
- rst asserted on edge 4 of an 8-bit transfer → edge 5 onward: dout_valid=0, busy=0, done never pulses; a new start is then accepted normally.
- With QSER_RELU_EN defined: din=-1000, msbidx=7, prec=8 → 0,0,0,0,0,0,0,0. din=1000 → 0,1,1,1,1,1,1,1.
